// File: rtl/nv_pkg.sv
// Shared NV signal-path definitions: DAC controller states, default timing
// constants and the registered SPI pin bundle.
package nv_pkg;

    localparam int unsigned DAC_CLK_DIV  = 2;
    localparam int unsigned DAC_CS_SETUP = 2;
    localparam int unsigned DAC_LDAC_W   = 2;
    localparam int unsigned DAC_DATA_W   = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHIFT = 2'd2,
        ST_LDAC  = 2'd3
    } dac_state_e;

    // One flop per DAC-side output, updated together every cycle.
    typedef struct packed {
        logic sclk;
        logic cs_n;
        logic din;
        logic ldac_n;
        logic busy;
        logic done;
    } dac_pins_t;

    localparam dac_pins_t DAC_PINS_IDLE = '{
        sclk:   1'b0,
        cs_n:   1'b1,
        din:    1'b0,
        ldac_n: 1'b1,
        busy:   1'b0,
        done:   1'b0
    };

endpackage

// File: rtl/dac_spi_tx_if.sv
// Start/done request handshake plus the 3-wire SPI and LDAC pins of the DAC.
interface dac_spi_tx_if #(
    parameter int unsigned DATA_W = 16
);
    logic              dac_start;
    logic [DATA_W-1:0] dac_data;
    logic              dac_busy;
    logic              dac_done;
    logic              dac_sclk;
    logic              dac_cs_n;
    logic              dac_din;
    logic              dac_ldac_n;

    modport master (
        output dac_start, dac_data,
        input  dac_busy, dac_done, dac_sclk, dac_cs_n, dac_din, dac_ldac_n
    );

    modport slave (
        input  dac_start, dac_data,
        output dac_busy, dac_done, dac_sclk, dac_cs_n, dac_din, dac_ldac_n
    );
endinterface

// File: rtl/dac_sclk_gen.sv
// SCLK half-period counter: phase starts low when enabled, toggles every
// CLK_DIV cycles, and bit_end_c marks the last cycle of each high phase.
module dac_sclk_gen #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic phase_q,
    output logic bit_end_c
);
    localparam int unsigned HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [HW-1:0] HLAST = HW'(CLK_DIV - 1);

    logic [HW-1:0] hcnt_q, hcnt_d;
    logic          phase_d;

    // Counter and phase clear whenever disabled so every frame starts low.
    always_comb begin
        hcnt_d  = '0;
        phase_d = 1'b0;
        if (en) begin
            if (hcnt_q == HLAST) begin
                hcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                hcnt_d  = hcnt_q + HW'(1);
                phase_d = phase_q;
            end
        end
    end

    assign bit_end_c = en && phase_q && (hcnt_q == HLAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hcnt_q  <= '0;
            phase_q <= 1'b0;
        end else begin
            hcnt_q  <= hcnt_d;
            phase_q <= phase_d;
        end
    end
endmodule

// File: rtl/dac_spi_tx.sv
// Serial DAC write controller: latches a code on start, shifts it MSB-first
// over SCLK/CS_n/DIN, then pulses LDAC_n and reports done.
module dac_spi_tx
    import nv_pkg::*;
#(
    parameter int unsigned CLK_DIV  = DAC_CLK_DIV,
    parameter int unsigned CS_SETUP = DAC_CS_SETUP,
    parameter int unsigned LDAC_W   = DAC_LDAC_W,
    parameter int unsigned DATA_W   = DAC_DATA_W
) (
    input  logic         clk,
    input  logic         reset,
    dac_spi_tx_if.slave  bus
);
    localparam int unsigned CW = $clog2(CS_SETUP + LDAC_W + 2);
    localparam int unsigned BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP - 1);
    localparam logic [CW-1:0] LDAC_LAST  = CW'(LDAC_W + 1);

    dac_state_e        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [DATA_W-1:0] sr_q, sr_d;
    dac_pins_t         pins_q, pins_d;
    logic              phase_q;
    logic              bit_end_c;

    dac_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk       (clk),
        .reset     (reset),
        .en        (state_q == ST_SHIFT),
        .phase_q   (phase_q),
        .bit_end_c (bit_end_c)
    );

    // Pins are a registered decode of the current state, so each pin pattern
    // appears one edge after the state that produces it. The LDAC state opens
    // with a cs_n-high gap cycle and closes with the done cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sr_d    = sr_q;
        pins_d  = DAC_PINS_IDLE;
        case (state_q)
            ST_IDLE: begin
                if (bus.dac_start) begin
                    sr_d    = bus.dac_data;
                    cnt_d   = '0;
                    bit_d   = BW'(DATA_W - 1);
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                pins_d.cs_n = 1'b0;
                pins_d.busy = 1'b1;
                pins_d.din  = sr_q[DATA_W-1];
                if (cnt_q == SETUP_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_SHIFT: begin
                pins_d.cs_n = 1'b0;
                pins_d.busy = 1'b1;
                pins_d.din  = sr_q[DATA_W-1];
                pins_d.sclk = phase_q;
                // Shifting at the end of a high phase moves din at the next low phase.
                if (bit_end_c) begin
                    sr_d = {sr_q[DATA_W-2:0], 1'b0};
                    if (bit_q == '0) begin
                        cnt_d   = '0;
                        state_d = ST_LDAC;
                    end else begin
                        bit_d = bit_q - BW'(1);
                    end
                end
            end
            ST_LDAC: begin
                pins_d.busy = 1'b1;
                if (cnt_q == LDAC_LAST) begin
                    pins_d.busy = 1'b0;
                    pins_d.done = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q != '0) begin
                        pins_d.ldac_n = 1'b0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sr_q    <= '0;
            pins_q  <= DAC_PINS_IDLE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sr_q    <= sr_d;
            pins_q  <= pins_d;
        end
    end

    assign bus.dac_sclk   = pins_q.sclk;
    assign bus.dac_cs_n   = pins_q.cs_n;
    assign bus.dac_din    = pins_q.din;
    assign bus.dac_ldac_n = pins_q.ldac_n;
    assign bus.dac_busy   = pins_q.busy;
    assign bus.dac_done   = pins_q.done;
endmodule

// File: tb/tb_dac_spi_tx.sv
// Directed bench for dac_spi_tx: default and fastest timing instances,
// vector table of single frames plus busy-start, back-to-back and reset cases.
module tb_dac_spi_tx;

    logic clk = 1'b0;
    logic reset;
    logic sel;
    always #5 clk = ~clk;

    dac_spi_tx_if #(.DATA_W(16)) if_a ();
    dac_spi_tx_if #(.DATA_W(16)) if_b ();

    dac_spi_tx u_dut_a (.clk(clk), .reset(reset), .bus(if_a));
    dac_spi_tx #(.CLK_DIV(1), .CS_SETUP(1), .LDAC_W(1), .DATA_W(16))
        u_dut_b (.clk(clk), .reset(reset), .bus(if_b));

    logic m_sclk, m_cs_n, m_din, m_ldac_n, m_busy, m_done;
    always_comb begin
        if (sel) begin
            m_sclk = if_b.dac_sclk;  m_cs_n = if_b.dac_cs_n;   m_din  = if_b.dac_din;
            m_ldac_n = if_b.dac_ldac_n; m_busy = if_b.dac_busy; m_done = if_b.dac_done;
        end else begin
            m_sclk = if_a.dac_sclk;  m_cs_n = if_a.dac_cs_n;   m_din  = if_a.dac_din;
            m_ldac_n = if_a.dac_ldac_n; m_busy = if_a.dac_busy; m_done = if_a.dac_done;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int word; int rises;
        int cs_first; int cs_last; int cs_cnt;
        int ldac_first; int ldac_last; int ldac_cnt;
        int done_edge; int done_cnt;
        int busy1; int busy_done; int sclk_viol; int din_chg;
    } rec_t;

    typedef struct {
        logic        s;
        logic [15:0] d;
        int          t;
        int          ldw;
        logic        dconst;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h (%0d) expected 0x%0h (%0d)", name, act, act, exp, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic [15:0] d);
        if (sel) begin
            if_b.dac_start = st; if_b.dac_data = d;
        end else begin
            if_a.dac_start = st; if_a.dac_data = d;
        end
    endtask

    task automatic chk_idle(input string pfx);
        chk({pfx, ".cs_n"},   int'(m_cs_n),   1);
        chk({pfx, ".sclk"},   int'(m_sclk),   0);
        chk({pfx, ".din"},    int'(m_din),    0);
        chk({pfx, ".ldac_n"}, int'(m_ldac_n), 1);
        chk({pfx, ".busy"},   int'(m_busy),   0);
        chk({pfx, ".done"},   int'(m_done),   0);
    endtask

    // One start at edge 0, optional extra start pulse at edge pulse_e, observe ncyc edges.
    task automatic run_frame(input logic [15:0] d, input int pulse_e, input logic [15:0] pulse_d,
                             input int ncyc, output rec_t r);
        logic ps, pd, pc;
        logic [15:0] w;
        r.word = 0; r.rises = 0; r.cs_first = -1; r.cs_last = -1; r.cs_cnt = 0;
        r.ldac_first = -1; r.ldac_last = -1; r.ldac_cnt = 0; r.done_edge = -1; r.done_cnt = 0;
        r.busy1 = -1; r.busy_done = -1; r.sclk_viol = 0; r.din_chg = 0;
        w = '0;
        drive(1'b1, d);
        step();
        drive(1'b0, d);
        ps = m_sclk; pd = m_din; pc = m_cs_n;
        for (int e = 1; e <= ncyc; e++) begin
            if (e == pulse_e) drive(1'b1, pulse_d);
            step();
            if (e == pulse_e) drive(1'b0, pulse_d);
            if (!ps && m_sclk) begin
                w = {w[14:0], m_din};
                r.rises++;
            end
            if (!m_cs_n) begin
                if (r.cs_first < 0) r.cs_first = e;
                r.cs_last = e;
                r.cs_cnt++;
                if (!pc && (m_din != pd)) r.din_chg++;
            end
            if (!m_ldac_n) begin
                if (r.ldac_first < 0) r.ldac_first = e;
                r.ldac_last = e;
                r.ldac_cnt++;
            end
            if (m_done) begin
                if (r.done_edge < 0) r.done_edge = e;
                r.done_cnt++;
                r.busy_done = int'(m_busy);
            end
            if (e == 1) r.busy1 = int'(m_busy);
            if (m_cs_n && m_sclk) r.sclk_viol++;
            ps = m_sclk; pd = m_din; pc = m_cs_n;
        end
        r.word = int'(w);
    endtask

    task automatic check_rec(input string p, input rec_t r, input logic [15:0] d,
                             input int t, input int ldw, input logic dconst);
        chk({p, ".word"},       r.word,       int'(d));
        chk({p, ".rises"},      r.rises,      16);
        chk({p, ".cs_first"},   r.cs_first,   1);
        chk({p, ".cs_last"},    r.cs_last,    t - 1);
        chk({p, ".cs_cnt"},     r.cs_cnt,     t - 1);
        chk({p, ".ldac_first"}, r.ldac_first, t + 1);
        chk({p, ".ldac_last"},  r.ldac_last,  t + ldw);
        chk({p, ".ldac_cnt"},   r.ldac_cnt,   ldw);
        chk({p, ".done_edge"},  r.done_edge,  t + 1 + ldw);
        chk({p, ".done_cnt"},   r.done_cnt,   1);
        chk({p, ".busy1"},      r.busy1,      1);
        chk({p, ".busy_done"},  r.busy_done,  0);
        chk({p, ".sclk_viol"},  r.sclk_viol,  0);
        if (dconst) chk({p, ".din_chg"}, r.din_chg, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        vec_t        vecs [5];
        rec_t        r;
        logic        ps, pc;
        logic [15:0] w;
        int          k, act_cnt;
        int          exp_done [3];
        logic [15:0] exp_word [3];

        vecs[0] = '{1'b0, 16'hA5C3, 67, 2, 1'b0};
        vecs[1] = '{1'b0, 16'h0000, 67, 2, 1'b1};
        vecs[2] = '{1'b0, 16'hFFFF, 67, 2, 1'b1};
        vecs[3] = '{1'b1, 16'h8001, 34, 1, 1'b0};
        vecs[4] = '{1'b0, 16'h1234, 67, 2, 1'b0};

        sel = 1'b0;
        if_a.dac_start = 1'b0; if_a.dac_data = '0;
        if_b.dac_start = 1'b0; if_b.dac_data = '0;
        reset = 1'b0;
        repeat (3) step();
        chk_idle("reset_a");
        sel = 1'b1;
        chk_idle("reset_b");
        reset = 1'b1;
        step();

        // Single-frame vector table.
        for (int i = 0; i < 5; i++) begin
            sel = vecs[i].s;
            run_frame(vecs[i].d, -1, 16'h0000, vecs[i].t + vecs[i].ldw + 10, r);
            check_rec($sformatf("vec%0d", i), r, vecs[i].d, vecs[i].t, vecs[i].ldw, vecs[i].dconst);
        end

        // Start pulse while busy, with new data, must be ignored.
        sel = 1'b0;
        run_frame(16'hA5C3, 30, 16'hDEAD, 90, r);
        chk("busy_start.word",      r.word,      16'hA5C3);
        chk("busy_start.done_cnt",  r.done_cnt,  1);
        chk("busy_start.done_edge", r.done_edge, 70);
        chk("busy_start.cs_cnt",    r.cs_cnt,    66);

        // Start held high, data = 0x1000 + edge number: frames every 71 cycles.
        for (int j = 0; j < 3; j++) begin
            exp_done[j] = 70 + 71 * j;
            exp_word[j] = 16'h1000 + 16'(71 * j);
        end
        k = 0; w = '0; ps = m_sclk; pc = m_cs_n;
        drive(1'b1, 16'h1000);
        for (int e = 0; e <= 220; e++) begin
            step();
            if (pc && !m_cs_n) w = '0;
            if (!ps && m_sclk) w = {w[14:0], m_din};
            if (m_done) begin
                if (k < 3) begin
                    chk($sformatf("b2b%0d.done_edge", k), e, exp_done[k]);
                    chk($sformatf("b2b%0d.word", k), int'(w), int'(exp_word[k]));
                end
                k++;
            end
            ps = m_sclk; pc = m_cs_n;
            drive(1'b1, 16'h1000 + 16'(e + 1));
        end
        chk("b2b.done_cnt", k, 3);
        drive(1'b0, 16'h0000);
        repeat (80) step();
        chk_idle("b2b_end");

        // Asynchronous reset in the middle of SHIFT.
        drive(1'b1, 16'hA5C3);
        step();
        drive(1'b0, 16'hA5C3);
        for (int e = 1; e <= 40; e++) step();
        chk("rst.in_frame_cs_n", int'(m_cs_n), 0);
        chk("rst.in_frame_busy", int'(m_busy), 1);
        #2;
        reset = 1'b0;
        #1;
        chk_idle("rst_async");
        act_cnt = 0;
        repeat (3) begin
            step();
            if (!m_ldac_n || m_done || !m_cs_n || m_sclk) act_cnt++;
        end
        reset = 1'b1;
        repeat (80) begin
            step();
            if (!m_ldac_n || m_done || !m_cs_n || m_sclk) act_cnt++;
        end
        chk("rst.no_activity", act_cnt, 0);
        run_frame(16'hA5C3, -1, 16'h0000, 80, r);
        check_rec("rst_after", r, 16'hA5C3, 67, 2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dac_spi_tx.md
# dac_spi_tx

Serial DAC write controller for the NV signal path: the transmit-side counterpart of the ADC read controller. It accepts a 16-bit code with a start/done handshake, identical in style to the ADC launch/done pair, and shifts it MSB-first over a 3-wire SPI link (SCLK/CS_n/DIN) to a 16-bit voltage-output DAC. After the frame it pulses LDAC_n so that the analog output updates atomically. It drives the analog monitor of the CFAR threshold and the manual threshold from the system clock domain.

## Interface
Parameters:
- CLK_DIV, 2: clk cycles per SCLK half-period; legal range ≥1.
- CS_SETUP, 2: clk cycles from CS_n falling to the first SCLK falling phase; legal range ≥1.
- LDAC_W, 2: width of the LDAC_n low pulse, in clk cycles; legal range ≥1.
- DATA_W, 16: frame length in bits.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low.
- dac_start  in  1  request; sampled only in IDLE.
- dac_data  in  DATA_W  code to write; latched on acceptance.
- dac_busy  out  1  high while a frame or LDAC pulse is in progress.
- dac_done  out  1  one-cycle pulse when the update completes.
- dac_sclk  out  1  serial clock; idles low.
- dac_cs_n  out  1  chip select, active low.
- dac_din  out  1  serial data, MSB first.
- dac_ldac_n  out  1  load DAC, active low.

## Operation
- FSM states: IDLE → SETUP → SHIFT → LDAC → IDLE. dac_done is asserted on the LDAC→IDLE transition.
- IDLE: cs_n=1, sclk=0, ldac_n=1, busy=0. If dac_start=1 at an edge, latch dac_data into the shift register and go to SETUP.
- SETUP: cs_n=0 and din=bit[DATA_W-1] for CS_SETUP cycles. sclk stays 0.
- SHIFT: DATA_W bits. Each bit is sclk=0 for CLK_DIV cycles, then sclk=1 for CLK_DIV cycles.
  - din changes only at the start of a low phase, so the DAC samples on the rising edge.
  - Shift left; the bit counter counts down from DATA_W-1.
- Leaving SHIFT, on the edge after the last high phase: sclk=0, cs_n=1, din=0. The next cycle enters LDAC.
- LDAC: ldac_n=0 for LDAC_W cycles. Then dac_done=1 for one cycle, busy=0, and the FSM returns to IDLE.
- All outputs are registered. There is no combinational path from input to output.
- dac_start while busy is ignored: no queueing, no error flag.
- dac_start in the same cycle that dac_done is high is accepted, because the FSM is already in IDLE. Back-to-back frames are therefore allowed.
- dac_data changes after acceptance have no effect on the frame in flight.
- Reset, asynchronous at any point, forces the IDLE outputs immediately: cs_n=1, sclk=0, din=0, ldac_n=1, busy=0, done=0.
  - An aborted frame never produces an LDAC pulse, so the DAC keeps its previous output.

## Timing
- Edge 0 is the edge at which dac_start is accepted.
- cs_n=0 and busy=1 from edge 1.
- First sclk low phase at edge 1+CS_SETUP.
- cs_n=1 at edge T=1+CS_SETUP+2·DATA_W·CLK_DIV.
- ldac_n=0 over edges T+1 … T+LDAC_W.
- dac_done=1 and busy=0 at edge T+1+LDAC_W.
- With the defaults: T=67, ldac_n low on edges 68–69, done at 70. Frame rate is one update per 71 cycles when restarted on done.
- SCLK frequency is f_clk/(2·CLK_DIV).
- din holds stable for the full CLK_DIV cycles on each side of every sclk rising edge.

## Structure
- Shared package nv_pkg:
  - state enum (IDLE, SETUP, SHIFT, LDAC);
  - default constants DAC_CLK_DIV, DAC_CS_SETUP, DAC_LDAC_W, DAC_DATA_W.
- One sub-module is natural: dac_sclk_gen. It is a half-period counter producing a phase toggle plus a bit_end strobe.
- The FSM, shift register and bit counter stay in dac_spi_tx.
- The parent nv instantiates dac_spi_tx alongside the ADC controller.

## Test plan
- Defaults, dac_data=16'hA5C3, one start.
  - The bench deserializes din on sclk rising edges and must read 16'hA5C3.
  - cs_n low for edges 1–66; ldac_n low for edges 68–69; done pulse at edge 70 only.
- Data 16'h0000 and 16'hFFFF.
  - Exactly 16 rising sclk edges per frame.
  - din is constant for the whole frame.
  - sclk=0 whenever cs_n=1.
- Start held high continuously, data incrementing every cycle.
  - Frames are back-to-back, 71 cycles each.
  - Each frame carries the value present at its own acceptance edge.
- Start pulsed at edge 30 of a frame in flight.
  - The pulse is ignored and only one done is produced.
  - The captured word is unchanged.
- Reset asserted at edge 40, in SHIFT.
  - All outputs reach their idle values asynchronously.
  - No ldac_n pulse and no done; a new start after release completes normally.
- CLK_DIV=1, CS_SETUP=1, LDAC_W=1, data 16'h8001.
  - T=34, done at edge 36.
  - The bench reads 16'h8001.
